// File: rtl/sort_mem_responder.sv
// Word-addressed scratch memory answering one ar/r read and one aw/w/b write concurrently.
// Optional debug write port enabled by defining SORT_MEM_BACKDOOR_EN.
module sort_mem_responder #(
  parameter int ADDR_WDTH    = 4,
  parameter int DATA_WDTH    = 32,
  parameter int RESP_WDTH    = 1,
  parameter int MEM_DEPTH    = 16,
  parameter int READ_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_addr,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_addr,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp
`ifdef SORT_MEM_BACKDOOR_EN
  ,
  input  logic                 bd_we,
  input  logic [ADDR_WDTH-1:0] bd_addr,
  input  logic [DATA_WDTH-1:0] bd_wdata
`endif
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic W_COLLECT = 1'b0;
  localparam logic W_RESP    = 1'b1;

  localparam logic [ADDR_WDTH:0] DEPTH_L  = (ADDR_WDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]         LAT_L    = 4'(READ_LATENCY);
  localparam logic [RESP_WDTH-1:0] RESP_OK  = RESP_WDTH'(1);
  localparam logic [RESP_WDTH-1:0] RESP_ERR = '0;

  function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [DATA_WDTH-1:0] mem [MEM_DEPTH];

  // ---------------- read channel ----------------
  logic [1:0]           r_state;
  logic [ADDR_WDTH-1:0] r_addr;
  logic [3:0]           r_cnt;
  logic                 ar_fire, r_fire;
  logic                 r_sample;
  logic [ADDR_WDTH-1:0] r_sample_addr;

  assign ar_ready = (r_state == R_IDLE);
  assign r_valid  = (r_state == R_RESP);
  assign ar_fire  = ar_valid & ar_ready;
  assign r_fire   = r_valid & r_ready;

  // The memory word is captured on the edge that enters R_RESP, so with zero
  // latency the sample uses the incoming ar_addr rather than the latched one.
  always_comb begin
    r_sample      = 1'b0;
    r_sample_addr = r_addr;
    case (r_state)
      R_IDLE: begin
        if (ar_fire && (LAT_L == 4'd0)) begin
          r_sample      = 1'b1;
          r_sample_addr = ar_addr;
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd1) r_sample = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_resp  <= RESP_ERR;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_addr  <= ar_addr;
            r_cnt   <= LAT_L;
            r_state <= (LAT_L == 4'd0) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= R_RESP;
        end
        R_RESP: begin
          if (r_fire) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
      if (r_sample) begin
        if (in_range(r_sample_addr)) begin
          r_data <= mem[r_sample_addr];
          r_resp <= RESP_OK;
        end else begin
          r_data <= '0;
          r_resp <= RESP_ERR;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  logic                 w_state;
  logic                 aw_held, w_held;
  logic [ADDR_WDTH-1:0] aw_q;
  logic [DATA_WDTH-1:0] w_q;
  logic                 aw_fire, w_fire, b_fire;
  logic                 commit;
  logic [ADDR_WDTH-1:0] commit_addr;
  logic [DATA_WDTH-1:0] commit_data;

  assign b_valid  = (w_state == W_RESP);
  assign aw_ready = (w_state == W_COLLECT) && !aw_held;
  assign w_ready  = (w_state == W_COLLECT) && !w_held;
  assign aw_fire  = aw_valid & aw_ready;
  assign w_fire   = w_valid & w_ready;
  assign b_fire   = b_valid & b_ready;

  // Commit on the edge where both halves are available, whether captured
  // earlier or arriving now.
  assign commit      = (w_state == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
  assign commit_addr = aw_held ? aw_q : aw_addr;
  assign commit_data = w_held ? w_q : w_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      b_resp  <= RESP_ERR;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (aw_fire) begin
            aw_held <= 1'b1;
            aw_q    <= aw_addr;
          end
          if (w_fire) begin
            w_held <= 1'b1;
            w_q    <= w_data;
          end
          if (commit) begin
            w_state <= W_RESP;
            b_resp  <= in_range(commit_addr) ? RESP_OK : RESP_ERR;
          end
        end
        W_RESP: begin
          if (b_fire) begin
            w_state <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Memory has no reset; the backdoor assignment comes last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    if (rst_n && commit && in_range(commit_addr)) mem[commit_addr] <= commit_data;
`ifdef SORT_MEM_BACKDOOR_EN
    if (bd_we && in_range(bd_addr)) mem[bd_addr] <= bd_wdata;
`endif
  end

endmodule

// File: tb/tb_sort_mem_responder.sv
// Bench for sort_mem_responder: two instances (depth 16/latency 0 and depth 10/latency 2)
// share one stimulus stream and are checked every cycle against a transaction-level model.
module tb_sort_mem_responder;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ar_valid = 1'b0, r_ready = 1'b0, aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0;
  logic [AW-1:0] ar_addr = '0, aw_addr = '0;
  logic [DW-1:0] w_data = '0;

  logic [1:0]         ar_ready, r_valid, aw_ready, w_ready, b_valid, r_resp, b_resp;
  logic [1:0][DW-1:0] r_data;

  sort_mem_responder u0 (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready[0]), .ar_addr(ar_addr),
    .r_valid(r_valid[0]), .r_ready(r_ready), .r_data(r_data[0]), .r_resp(r_resp[0]),
    .aw_valid(aw_valid), .aw_ready(aw_ready[0]), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready[0]), .w_data(w_data),
    .b_valid(b_valid[0]), .b_ready(b_ready), .b_resp(b_resp[0])
`ifdef SORT_MEM_BACKDOOR_EN
    , .bd_we(1'b0), .bd_addr('0), .bd_wdata('0)
`endif
  );

  sort_mem_responder #(.MEM_DEPTH(10), .READ_LATENCY(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready[1]), .ar_addr(ar_addr),
    .r_valid(r_valid[1]), .r_ready(r_ready), .r_data(r_data[1]), .r_resp(r_resp[1]),
    .aw_valid(aw_valid), .aw_ready(aw_ready[1]), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready[1]), .w_data(w_data),
    .b_valid(b_valid[1]), .b_ready(b_ready), .b_resp(b_resp[1])
`ifdef SORT_MEM_BACKDOOR_EN
    , .bd_we(1'b0), .bd_addr('0), .bd_wdata('0)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---- transaction-level model, one slot per instance ----
  int          depth [2] = '{16, 10};
  int          lat   [2] = '{0, 2};
  logic [31:0] m_mem   [2][16];
  bit          m_known [2][16];

  bit          rd_busy [2], rd_valid [2], rd_known [2], rd_fresh [2], rd_resp [2];
  int          rd_wait [2], rd_addr [2];
  logic [31:0] rd_data [2];
  bit          aw_have [2], w_have [2], b_v [2], b_r [2], b_fresh [2];
  int          aw_a [2];
  logic [31:0] w_d [2];

  task automatic model_reset(input int k);
    rd_busy[k]  = 0;
    rd_valid[k] = 0;
    rd_fresh[k] = 1;
    aw_have[k]  = 0;
    w_have[k]   = 0;
    b_v[k]      = 0;
    b_fresh[k]  = 1;
  endtask

  task automatic model_step(input int k);
    bit take;
    int a;
    take = 0;
    if (!rd_busy[k]) begin
      if (ar_valid) begin
        rd_busy[k] = 1;
        rd_addr[k] = int'(ar_addr);
        rd_wait[k] = lat[k];
        if (lat[k] == 0) take = 1;
      end
    end else if (!rd_valid[k]) begin
      rd_wait[k] = rd_wait[k] - 1;
      if (rd_wait[k] == 0) take = 1;
    end else if (r_ready) begin
      rd_valid[k] = 0;
      rd_busy[k]  = 0;
    end
    // read sees memory as it was before any write on this edge
    if (take) begin
      a = rd_addr[k];
      rd_valid[k] = 1;
      rd_fresh[k] = 0;
      if (a < depth[k]) begin
        rd_data[k]  = m_mem[k][a];
        rd_resp[k]  = 1;
        rd_known[k] = m_known[k][a];
      end else begin
        rd_data[k]  = 32'h0;
        rd_resp[k]  = 0;
        rd_known[k] = 1;
      end
    end
    if (b_v[k]) begin
      if (b_ready) begin
        b_v[k]     = 0;
        aw_have[k] = 0;
        w_have[k]  = 0;
      end
    end else begin
      if (aw_valid && !aw_have[k]) begin
        aw_have[k] = 1;
        aw_a[k]    = int'(aw_addr);
      end
      if (w_valid && !w_have[k]) begin
        w_have[k] = 1;
        w_d[k]    = w_data;
      end
      if (aw_have[k] && w_have[k]) begin
        b_v[k]     = 1;
        b_fresh[k] = 0;
        if (aw_a[k] < depth[k]) begin
          m_mem[k][aw_a[k]]   = w_d[k];
          m_known[k][aw_a[k]] = 1;
          b_r[k] = 1;
        end else begin
          b_r[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
    end
  end

  task automatic cmp(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s u%0d at %0t: got %0h, expected %0h", nm, k, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cmp("ar_ready", k, 32'(ar_ready[k]), 32'(!rd_busy[k]));
      cmp("r_valid",  k, 32'(r_valid[k]),  32'(rd_valid[k]));
      cmp("aw_ready", k, 32'(aw_ready[k]), 32'(!aw_have[k] && !b_v[k]));
      cmp("w_ready",  k, 32'(w_ready[k]),  32'(!w_have[k] && !b_v[k]));
      cmp("b_valid",  k, 32'(b_valid[k]),  32'(b_v[k]));
      if (rd_valid[k]) begin
        cmp("r_resp", k, 32'(r_resp[k]), 32'(rd_resp[k]));
        if (rd_known[k]) cmp("r_data", k, r_data[k], rd_data[k]);
      end else if (rd_fresh[k]) begin
        cmp("r_resp_rst", k, 32'(r_resp[k]), 32'h0);
        cmp("r_data_rst", k, r_data[k], 32'h0);
      end
      if (b_v[k]) cmp("b_resp", k, 32'(b_resp[k]), 32'(b_r[k]));
      else if (b_fresh[k]) cmp("b_resp_rst", k, 32'(b_resp[k]), 32'h0);
    end
  end

  // inputs change 1 time unit after the falling edge, clear of both sampling points
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    aw_valid = 1'b1; aw_addr = a; w_valid = 1'b1; w_data = d; b_ready = 1'b0;
    cyc();
    aw_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic b_ack();
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // write 0xDEADBEEF to 3, aw and w together
    wr(4'd3, 32'hDEADBEEF);
    cmp("lit_wr_bvalid", 0, 32'(b_valid[0]), 32'h1);
    cmp("lit_wr_bresp", 0, 32'(b_resp[0]), 32'h1);
    cmp("lit_wr_awready", 0, 32'(aw_ready[0]), 32'h0);
    b_ack();
    cmp("lit_wr_bdone", 0, 32'(b_valid[0]), 32'h0);

    // read 3 with r_ready held low: latency 0 vs latency 2
    ar_valid = 1'b1; ar_addr = 4'd3; r_ready = 1'b0;
    cyc();
    ar_valid = 1'b0;
    cmp("lit_rd_valid_l0", 0, 32'(r_valid[0]), 32'h1);
    cmp("lit_rd_data_l0", 0, r_data[0], 32'hDEADBEEF);
    cmp("lit_rd_resp_l0", 0, 32'(r_resp[0]), 32'h1);
    cmp("lit_rd_early_l2", 1, 32'(r_valid[1]), 32'h0);
    cyc();
    cmp("lit_rd_early_l2", 1, 32'(r_valid[1]), 32'h0);
    cyc();
    cmp("lit_rd_valid_l2", 1, 32'(r_valid[1]), 32'h1);
    cmp("lit_rd_data_l2", 1, r_data[1], 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      cyc();
      cmp("lit_rd_hold", 1, r_data[1], 32'hDEADBEEF);
      cmp("lit_rd_hold_v", 1, 32'(r_valid[1]), 32'h1);
    end
    r_ready = 1'b1;
    cyc();
    r_ready = 1'b0;
    cmp("lit_rd_done", 1, 32'(r_valid[1]), 32'h0);

    // split write: w first, aw four cycles later
    w_valid = 1'b1; w_data = 32'h5;
    cyc();
    w_valid = 1'b0;
    cmp("lit_split_wready", 0, 32'(w_ready[0]), 32'h0);
    cmp("lit_split_awready", 0, 32'(aw_ready[0]), 32'h1);
    repeat (3) cyc();
    cmp("lit_split_nob", 0, 32'(b_valid[0]), 32'h0);
    aw_valid = 1'b1; aw_addr = 4'd7;
    cyc();
    aw_valid = 1'b0;
    cmp("lit_split_bvalid", 0, 32'(b_valid[0]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      cmp("lit_split_bhold", 1, 32'(b_valid[1]), 32'h1);
    end
    b_ack();
    ar_valid = 1'b1; ar_addr = 4'd7; r_ready = 1'b1;
    cyc();
    ar_valid = 1'b0;
    cmp("lit_split_rd", 0, r_data[0], 32'h5);
    repeat (3) cyc();
    r_ready = 1'b0;

    // out of range on the depth-10 instance, and no aliasing of 15 onto 5
    wr(4'd5, 32'h55);
    b_ack();
    wr(4'd15, 32'hA5);
    cmp("lit_oor_bresp", 1, 32'(b_resp[1]), 32'h0);
    cmp("lit_inr_bresp", 0, 32'(b_resp[0]), 32'h1);
    b_ack();
    ar_valid = 1'b1; ar_addr = 4'd12; r_ready = 1'b0;
    cyc();
    ar_valid = 1'b0;
    repeat (2) cyc();
    cmp("lit_oor_rresp", 1, 32'(r_resp[1]), 32'h0);
    cmp("lit_oor_rdata", 1, r_data[1], 32'h0);
    r_ready = 1'b1;
    cyc();
    r_ready = 1'b0;
    ar_valid = 1'b1; ar_addr = 4'd5;
    cyc();
    ar_valid = 1'b0;
    repeat (2) cyc();
    cmp("lit_noalias", 1, r_data[1], 32'h55);
    r_ready = 1'b1;
    cyc();
    r_ready = 1'b0;

    // read sample and write commit to addr 2 on the same edge (latency-0 instance)
    wr(4'd2, 32'h11);
    b_ack();
    ar_valid = 1'b1; ar_addr = 4'd2; r_ready = 1'b0;
    aw_valid = 1'b1; aw_addr = 4'd2; w_valid = 1'b1; w_data = 32'h22;
    cyc();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    cmp("lit_coll_old", 0, r_data[0], 32'h11);
    repeat (2) cyc();
    cmp("lit_coll_late", 1, r_data[1], 32'h22);
    r_ready = 1'b1; b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    ar_valid = 1'b1;
    cyc();
    ar_valid = 1'b0;
    cmp("lit_coll_new", 0, r_data[0], 32'h22);
    repeat (3) cyc();
    r_ready = 1'b0;

    // reset in the middle of a read
    ar_valid = 1'b1; ar_addr = 4'd2;
    cyc();
    ar_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      cmp("lit_rst_rvalid", k, 32'(r_valid[k]), 32'h0);
      cmp("lit_rst_arready", k, 32'(ar_ready[k]), 32'h1);
      cmp("lit_rst_awready", k, 32'(aw_ready[k]), 32'h1);
      cmp("lit_rst_wready", k, 32'(w_ready[k]), 32'h1);
      cmp("lit_rst_bvalid", k, 32'(b_valid[k]), 32'h0);
    end
    rst_n = 1'b1;
    cyc();

    // randomized traffic, addresses biased low to provoke collisions
    for (int i = 0; i < 4000; i++) begin
      ar_valid = ($urandom_range(0, 9) < 6);
      r_ready  = ($urandom_range(0, 9) < 6);
      aw_valid = ($urandom_range(0, 9) < 5);
      w_valid  = ($urandom_range(0, 9) < 5);
      b_ready  = ($urandom_range(0, 9) < 6);
      ar_addr  = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      aw_addr  = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      w_data   = $urandom;
      rst_n    = ($urandom_range(0, 599) != 0);
      cyc();
    end
    rst_n = 1'b1;
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    r_ready = 1'b1; b_ready = 1'b1;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort_mem_responder.md
Name: sort_mem_responder

Overview:
- Memory-side responder for the sort controller's read channel (ar/r) and the write submodule's write channel (aw/w/b).
- Holds the array being sorted in a word-addressed register file and answers one read and one write transaction concurrently.
- Used as the memory model in system benches and as the on-chip scratch memory in the sort-circuit top level.

Parameters:
- ADDR_WDTH, 4, word-address width; one address selects one word.
- DATA_WDTH, 32, data word width.
- RESP_WDTH, 1, response width. 1 = OK, 0 = error, matching the controller's check.
- MEM_DEPTH, 16, number of implemented words, at most 2**ADDR_WDTH.
- READ_LATENCY, 0, extra wait cycles between the ar handshake and r_valid; range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address accepted.
- ar_addr  in  ADDR_WDTH  read word address.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data consumed.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address accepted.
- aw_addr  in  ADDR_WDTH  write word address.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data accepted.
- w_data  in  DATA_WDTH  write data.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response consumed.
- b_resp  out  RESP_WDTH  write response.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0, ar_ready=1, aw_ready=1, w_ready=1. Memory array is not reset.
- Reset mid-transaction: all in-flight transactions are discarded and no response is issued. Writes already committed remain in memory.
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1. Once r_valid or b_valid rises, it stays high, with r_data/r_resp or b_resp stable, until the matching ready handshake.

Read FSM:
- R_IDLE: ar_ready=1. On the ar handshake, latch ar_addr and load the latency counter with READ_LATENCY. Go to R_WAIT if READ_LATENCY>0, else R_RESP.
- R_WAIT: ar_ready=0. Decrement the counter each cycle; on reaching 0, go to R_RESP.
- On entry to R_RESP: sample r_data=mem[addr] and r_resp=1 if addr<MEM_DEPTH. Otherwise r_data=0 and r_resp=0.
- R_RESP: r_valid=1, ar_ready=0. On the r handshake, go to R_IDLE.
- Minimum latency: r_valid high one cycle after the ar handshake, plus READ_LATENCY cycles.
- Back-to-back: a new ar is accepted no earlier than the cycle after the r handshake.

Write FSM:
- W_COLLECT: aw_ready=1 until aw is captured; w_ready=1 until w is captured.
- aw and w may arrive in either order or in the same cycle. Each ready drops after its own capture.
- The edge on which both are held commits the write and enters W_RESP. The commit is mem[addr]=data when addr<MEM_DEPTH, with b_resp=1. Otherwise there is no write and b_resp=0.
- W_RESP: b_valid=1, aw_ready=0, w_ready=0. On the b handshake, go to W_COLLECT with both captures cleared.

Collisions and ranges:
- Read/write collision: if the write commit and the r_data sample fall on the same edge to the same address, r_data returns the pre-write value.
- Reads and writes otherwise proceed independently.
- Out-of-range: an address at or above MEM_DEPTH gets an error response and never aliases.

Optional Feature:
- Macro: SORT_MEM_BACKDOOR_EN.
- Enabled: adds three input ports, bd_we (1), bd_addr (ADDR_WDTH) and bd_wdata (DATA_WDTH). When bd_we=1 and bd_addr<MEM_DEPTH, the edge writes mem[bd_addr]=bd_wdata, ignoring the FSMs and issuing no responses.
- Same-edge, same-address conflict with a write commit: the backdoor value wins.
- Disabled: the ports do not exist and memory is written only through aw/w.

Test Plan:
- Reset: assert rst_n=0 mid-read -> next cycle r_valid=0, ar_ready=1, aw_ready=1, w_ready=1, b_valid=0.
- Write then read, READ_LATENCY=0: write 0xDEADBEEF to addr 3 (aw and w in the same cycle) -> b_valid next cycle, b_resp=1. Then read addr 3 -> r_valid one cycle after the ar handshake, r_data=0xDEADBEEF, r_resp=1.
- Split write: w first (data 0x5) with aw 4 cycles later (addr 7) -> w_ready drops after the w capture, b_valid the cycle after the aw handshake, and a later read of 7 returns 0x5.
- Backpressure, READ_LATENCY=2: hold r_ready=0 for 5 cycles -> r_valid rises 3 cycles after ar, then r_data/r_resp stay constant until r_ready=1. Hold b_ready=0 similarly -> b_valid is held.
- Out-of-range, MEM_DEPTH=10: read addr 12 -> r_resp=0, r_data=0. Write addr 15 -> b_resp=0, and mem[5] is unchanged (no aliasing).
- Collision: read of addr 2 (old 0x11) samples on the same edge as a write commit of 0x22 to addr 2 -> r_data=0x11, and the next read returns 0x22.
